// File: rtl/poker_dealer_betting_round_if.sv
// Player <-> dealer handshake and per-player feedback bundle.
interface poker_dealer_betting_round_if;
  logic       p0_output_valid;
  logic       p1_output_valid;
  logic [2:0] p0_action;
  logic [2:0] p1_action;
  logic [7:0] p0_make_bet;
  logic [7:0] p1_make_bet;
  logic       p0_dealer_request_action;
  logic       p1_dealer_request_action;
  logic       p0_dealer_acknowledge;
  logic       p1_dealer_acknowledge;
  logic       p0_invalid_move;
  logic       p1_invalid_move;
  logic [2:0] p0_action_opponent;
  logic [2:0] p1_action_opponent;
  logic [7:0] p0_bet_opponent;
  logic [7:0] p1_bet_opponent;
  logic [7:0] p0_money_left;
  logic [7:0] p1_money_left;

  // Player side: presents moves, consumes dealer feedback.
  modport master (
    output p0_output_valid, p1_output_valid, p0_action, p1_action,
           p0_make_bet, p1_make_bet,
    input  p0_dealer_request_action, p1_dealer_request_action,
           p0_dealer_acknowledge, p1_dealer_acknowledge,
           p0_invalid_move, p1_invalid_move,
           p0_action_opponent, p1_action_opponent,
           p0_bet_opponent, p1_bet_opponent,
           p0_money_left, p1_money_left
  );

  // Dealer side: consumes moves, produces feedback.
  modport slave (
    input  p0_output_valid, p1_output_valid, p0_action, p1_action,
           p0_make_bet, p1_make_bet,
    output p0_dealer_request_action, p1_dealer_request_action,
           p0_dealer_acknowledge, p1_dealer_acknowledge,
           p0_invalid_move, p1_invalid_move,
           p0_action_opponent, p1_action_opponent,
           p0_bet_opponent, p1_bet_opponent,
           p0_money_left, p1_money_left
  );
endinterface

// File: rtl/poker_dealer_betting_round.sv
// Dealer betting-round controller: requests moves in turn, validates them
// against stacks and the amount to call, and maintains pot/stacks/feedback.
module poker_dealer_betting_round #(
  parameter int unsigned MAX_INVALID = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hand_start,
  input  logic [7:0] stack0_init,
  input  logic [7:0] stack1_init,
  input  logic       round_start,
  input  logic       first_player,
  poker_dealer_betting_round_if.slave bus,
  output logic [7:0] pot_size,
  output logic       betting_round_done,
  output logic       next_deal,
  output logic       winner
);
  localparam int unsigned CW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned IW = 3;

  localparam logic [AW-1:0] NO_ACTION = 3'b000;
  localparam logic [AW-1:0] FOLD      = 3'b001;
  localparam logic [AW-1:0] CHECK     = 3'b010;
  localparam logic [AW-1:0] ALL_IN    = 3'b011;
  localparam logic [AW-1:0] CALL      = 3'b100;
  localparam logic [AW-1:0] BET       = 3'b110;
  localparam logic [AW-1:0] RAISE     = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_VALID, S_EVAL, S_ACK, S_WAIT_DROP, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          cur_q;
  logic [1:0]    acted_q;
  logic [CW-1:0] stack_q     [2];
  logic [CW-1:0] committed_q [2];
  logic [IW-1:0] inv_q       [2];
  logic [AW-1:0] opp_act_q   [2];
  logic [CW-1:0] opp_bet_q   [2];
  logic [CW-1:0] pot_q;
  logic [AW-1:0] act_q;
  logic [CW-1:0] bet_q;
  logic          legal_q;
  logic          fold_q;

  logic [1:0]    req_q, req_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    invp_q, invp_d;
  logic          done_q, done_d;
  logic          deal_q, deal_d;
  logic          winner_q, winner_d;

  logic          cur_valid_c;
  logic [CW-1:0] cur_stack_c;
  logic [CW-1:0] cur_comm_c;
  logic [CW-1:0] oth_comm_c;
  logic [CW-1:0] to_call_c;
  logic [CW:0]   raise_sum_c;
  logic          legal_c;
  logic [CW-1:0] paid_c;
  logic          complete_c;
  logic          forced_fold_c;

  assign cur_valid_c   = cur_q ? bus.p1_output_valid : bus.p0_output_valid;
  assign cur_stack_c   = stack_q[cur_q];
  assign cur_comm_c    = committed_q[cur_q];
  assign oth_comm_c    = committed_q[~cur_q];
  // An over-committed current player owes nothing.
  assign to_call_c     = (oth_comm_c > cur_comm_c) ? (oth_comm_c - cur_comm_c) : '0;
  assign forced_fold_c = !legal_q && (inv_q[cur_q] >= IW'(MAX_INVALID));
  assign complete_c    = acted_q[0] && acted_q[1] &&
                         ((committed_q[0] == committed_q[1]) ||
                          ((committed_q[0] < committed_q[1]) && (stack_q[0] == '0)) ||
                          ((committed_q[1] < committed_q[0]) && (stack_q[1] == '0)));

  // Legality and chip cost of the latched move.
  always_comb begin
    legal_c     = 1'b0;
    paid_c      = '0;
    raise_sum_c = {1'b0, to_call_c} + {1'b0, bet_q};
    case (act_q)
      FOLD:   legal_c = 1'b1;
      CHECK:  legal_c = (to_call_c == '0);
      CALL: begin
        legal_c = (to_call_c != '0) && (to_call_c <= cur_stack_c);
        paid_c  = to_call_c;
      end
      BET: begin
        legal_c = (to_call_c == '0) && (bet_q != '0) && (bet_q <= cur_stack_c);
        paid_c  = bet_q;
      end
      RAISE: begin
        legal_c = (to_call_c != '0) && (bet_q != '0) && (raise_sum_c <= {1'b0, cur_stack_c});
        paid_c  = raise_sum_c[CW-1:0];
      end
      ALL_IN: begin
        legal_c = (cur_stack_c != '0);
        paid_c  = cur_stack_c;
      end
      NO_ACTION: legal_c = 1'b0;
      default:   legal_c = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a new hand aborts whatever is in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (round_start) state_d = S_REQ;
      S_REQ:        state_d = S_WAIT_VALID;
      S_WAIT_VALID: if (cur_valid_c) state_d = S_EVAL;
      S_EVAL:       state_d = S_ACK;
      S_ACK:        state_d = S_WAIT_DROP;
      S_WAIT_DROP: begin
        if (!cur_valid_c) begin
          if (fold_q || forced_fold_c) state_d = S_IDLE;
          else if (!legal_q)           state_d = S_REQ;
          else                         state_d = S_NEXT;
        end
      end
      S_NEXT:       state_d = complete_c ? S_DONE : S_REQ;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (hand_start) state_d = S_IDLE;
  end

  // Next values of the request level and the one-cycle pulses.
  always_comb begin
    req_d    = req_q;
    ack_d    = '0;
    invp_d   = '0;
    done_d   = 1'b0;
    deal_d   = 1'b0;
    winner_d = winner_q;
    if (hand_start) begin
      req_d = '0;
    end else begin
      case (state_q)
        S_REQ:  req_d[cur_q] = 1'b1;
        S_EVAL: begin
          req_d[cur_q]  = 1'b0;
          ack_d[cur_q]  = 1'b1;
          invp_d[cur_q] = !legal_c;
        end
        S_WAIT_DROP: begin
          if (!cur_valid_c && (fold_q || forced_fold_c)) begin
            deal_d   = 1'b1;
            winner_d = ~cur_q;
          end
        end
        S_NEXT:  done_d = complete_c;
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      ack_q    <= '0;
      invp_q   <= '0;
      done_q   <= 1'b0;
      deal_q   <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      req_q    <= req_d;
      ack_q    <= ack_d;
      invp_q   <= invp_d;
      done_q   <= done_d;
      deal_q   <= deal_d;
      winner_q <= winner_d;
    end
  end

  // Chip accounting, move latch and turn tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q          <= 1'b0;
      acted_q        <= '0;
      pot_q          <= '0;
      act_q          <= NO_ACTION;
      bet_q          <= '0;
      legal_q        <= 1'b0;
      fold_q         <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        stack_q[i]     <= '0;
        committed_q[i] <= '0;
        inv_q[i]       <= '0;
        opp_act_q[i]   <= NO_ACTION;
        opp_bet_q[i]   <= '0;
      end
    end else if (hand_start) begin
      stack_q[0]     <= stack0_init;
      stack_q[1]     <= stack1_init;
      committed_q[0] <= '0;
      committed_q[1] <= '0;
      inv_q[0]       <= '0;
      inv_q[1]       <= '0;
      pot_q          <= '0;
      acted_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (round_start) begin
            cur_q          <= first_player;
            acted_q        <= '0;
            committed_q[0] <= '0;
            committed_q[1] <= '0;
          end
        end
        S_WAIT_VALID: begin
          if (cur_valid_c) begin
            act_q <= cur_q ? bus.p1_action   : bus.p0_action;
            bet_q <= cur_q ? bus.p1_make_bet : bus.p0_make_bet;
          end
        end
        S_EVAL: begin
          legal_q <= legal_c;
          fold_q  <= legal_c && (act_q == FOLD);
          if (legal_c) begin
            stack_q[cur_q]     <= cur_stack_c - paid_c;
            committed_q[cur_q] <= cur_comm_c + paid_c;
            pot_q              <= pot_q + paid_c;
            opp_act_q[~cur_q]  <= act_q;
            opp_bet_q[~cur_q]  <= paid_c;
            acted_q[cur_q]     <= 1'b1;
            inv_q[cur_q]       <= '0;
          end else if (inv_q[cur_q] != '1) begin
            inv_q[cur_q] <= inv_q[cur_q] + IW'(1);
          end
        end
        S_NEXT: if (!complete_c) cur_q <= ~cur_q;
        default: ;
      endcase
    end
  end

  assign bus.p0_dealer_request_action = req_q[0];
  assign bus.p1_dealer_request_action = req_q[1];
  assign bus.p0_dealer_acknowledge    = ack_q[0];
  assign bus.p1_dealer_acknowledge    = ack_q[1];
  assign bus.p0_invalid_move          = invp_q[0];
  assign bus.p1_invalid_move          = invp_q[1];
  assign bus.p0_action_opponent       = opp_act_q[0];
  assign bus.p1_action_opponent       = opp_act_q[1];
  assign bus.p0_bet_opponent          = opp_bet_q[0];
  assign bus.p1_bet_opponent          = opp_bet_q[1];
  assign bus.p0_money_left            = stack_q[0];
  assign bus.p1_money_left            = stack_q[1];
  assign pot_size                     = pot_q;
  assign betting_round_done           = done_q;
  assign next_deal                    = deal_q;
  assign winner                       = winner_q;
endmodule

// File: tb/tb_poker_dealer_betting_round.sv
// Directed bench for the dealer betting-round controller with a move scoreboard.
module tb_poker_dealer_betting_round;
  localparam logic [2:0] A_NONE  = 3'b000;
  localparam logic [2:0] A_FOLD  = 3'b001;
  localparam logic [2:0] A_CHECK = 3'b010;
  localparam logic [2:0] A_ALLIN = 3'b011;
  localparam logic [2:0] A_CALL  = 3'b100;
  localparam logic [2:0] A_BET   = 3'b110;
  localparam logic [2:0] A_RAISE = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic       hand_start;
  logic [7:0] stack0_init;
  logic [7:0] stack1_init;
  logic       round_start;
  logic       first_player;
  logic [7:0] pot_size;
  logic       betting_round_done;
  logic       next_deal;
  logic       winner;

  poker_dealer_betting_round_if bus ();

  poker_dealer_betting_round #(.MAX_INVALID(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .hand_start         (hand_start),
    .stack0_init        (stack0_init),
    .stack1_init        (stack1_init),
    .round_start        (round_start),
    .first_player       (first_player),
    .bus                (bus),
    .pot_size           (pot_size),
    .betting_round_done (betting_round_done),
    .next_deal          (next_deal),
    .winner             (winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic p;
    logic inv;
  } exp_t;

  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned done_cnt = 0;
  int unsigned deal_cnt = 0;
  int unsigned ack_cnt  = 0;
  int unsigned inv_cnt  = 0;
  logic        winner_seen = 1'b0;

  // Pulse counters sampled at each rising edge.
  always @(posedge clk) begin
    if (betting_round_done === 1'b1) done_cnt++;
    if (next_deal === 1'b1) begin
      deal_cnt++;
      winner_seen = winner;
    end
    if (bus.p0_dealer_acknowledge === 1'b1 || bus.p1_dealer_acknowledge === 1'b1) ack_cnt++;
    if (bus.p0_invalid_move === 1'b1 || bus.p1_invalid_move === 1'b1) inv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic new_hand(input logic [7:0] s0, input logic [7:0] s1);
    @(negedge clk);
    hand_start  = 1'b1;
    stack0_init = s0;
    stack1_init = s1;
    @(negedge clk);
    hand_start  = 1'b0;
    chk("load_money0", 32'(bus.p0_money_left), 32'(s0));
    chk("load_money1", 32'(bus.p1_money_left), 32'(s1));
    chk("load_pot", 32'(pot_size), 32'd0);
  endtask

  task automatic start_round(input logic f);
    @(negedge clk);
    round_start  = 1'b1;
    first_player = f;
    @(negedge clk);
    round_start  = 1'b0;
  endtask

  task automatic drive(input logic p, input logic v, input logic [2:0] act, input logic [7:0] bet);
    if (p) begin
      bus.p1_output_valid = v;
      bus.p1_action       = act;
      bus.p1_make_bet     = bet;
    end else begin
      bus.p0_output_valid = v;
      bus.p0_action       = act;
      bus.p0_make_bet     = bet;
    end
  endtask

  // Wait for the request, present a move, and score the acknowledge.
  task automatic do_move(input logic p, input logic [2:0] act, input logic [7:0] bet,
                         input logic exp_inv);
    int n;
    exp_t e;
    exp_t got;
    logic [1:0] want;
    n = 0;
    while (((p ? bus.p1_dealer_request_action : bus.p0_dealer_request_action) !== 1'b1)
           && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("request_seen", 32'(n < 40), 32'd1);
    chk("other_request_low",
        32'(p ? bus.p0_dealer_request_action : bus.p1_dealer_request_action), 32'd0);
    drive(p, 1'b1, act, bet);
    e.p   = p;
    e.inv = exp_inv;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.p0_dealer_acknowledge === 1'b1 || bus.p1_dealer_acknowledge === 1'b1)
               && n < 40);
    chk("ack_latency", 32'(n), 32'd2);
    if (n < 40 && sb.size() > 0) begin
      got  = sb.pop_front();
      want = got.p ? 2'b10 : 2'b01;
      chk("ack_player", 32'({bus.p1_dealer_acknowledge, bus.p0_dealer_acknowledge}), 32'(want));
      chk("invalid_pulse", 32'({bus.p1_invalid_move, bus.p0_invalid_move}),
          got.inv ? 32'(want) : 32'd0);
      chk("request_dropped",
          32'({bus.p1_dealer_request_action, bus.p0_dealer_request_action}), 32'd0);
    end
    drive(p, 1'b0, A_NONE, 8'd0);
  endtask

  task automatic wait_done(input int unsigned base);
    int n;
    n = 0;
    while (done_cnt == base && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(n < 30), 32'd1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - base, 32'd1);
  endtask

  task automatic wait_deal(input int unsigned base);
    int n;
    n = 0;
    while (deal_cnt == base && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("deal_seen", 32'(n < 30), 32'd1);
    repeat (3) @(negedge clk);
    chk("deal_once", deal_cnt - base, 32'd1);
  endtask

  initial begin
    int unsigned base_done;
    int unsigned base_deal;
    int unsigned base_inv;
    int unsigned base_ack;
    int n;

    rst          = 1'b1;
    hand_start   = 1'b0;
    stack0_init  = 8'd0;
    stack1_init  = 8'd0;
    round_start  = 1'b0;
    first_player = 1'b0;
    drive(1'b0, 1'b0, A_NONE, 8'd0);
    drive(1'b1, 1'b0, A_NONE, 8'd0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_pot", 32'(pot_size), 32'd0);
    chk("rst_money0", 32'(bus.p0_money_left), 32'd0);
    chk("rst_req", 32'({bus.p1_dealer_request_action, bus.p0_dealer_request_action}), 32'd0);
    chk("rst_act_opp", 32'({bus.p1_action_opponent, bus.p0_action_opponent}), 32'd0);
    chk("rst_pulses", 32'({betting_round_done, next_deal, winner}), 32'd0);
    rst = 1'b0;

    // Bet / call
    new_hand(8'd100, 8'd100);
    start_round(1'b0);
    base_done = done_cnt;
    do_move(1'b0, A_BET, 8'd10, 1'b0);
    do_move(1'b1, A_CALL, 8'd0, 1'b0);
    wait_done(base_done);
    chk("bc_pot", 32'(pot_size), 32'd20);
    chk("bc_money0", 32'(bus.p0_money_left), 32'd90);
    chk("bc_money1", 32'(bus.p1_money_left), 32'd90);
    chk("bc_p1_act_opp", 32'(bus.p1_action_opponent), 32'(A_BET));
    chk("bc_p1_bet_opp", 32'(bus.p1_bet_opponent), 32'd10);
    chk("bc_p0_act_opp", 32'(bus.p0_action_opponent), 32'(A_CALL));
    chk("bc_p0_bet_opp", 32'(bus.p0_bet_opponent), 32'd10);

    // Check / check
    start_round(1'b0);
    base_done = done_cnt;
    base_inv  = inv_cnt;
    do_move(1'b0, A_CHECK, 8'd0, 1'b0);
    do_move(1'b1, A_CHECK, 8'd0, 1'b0);
    wait_done(base_done);
    chk("cc_pot", 32'(pot_size), 32'd20);
    chk("cc_money1", 32'(bus.p1_money_left), 32'd90);
    chk("cc_no_invalid", inv_cnt - base_inv, 32'd0);
    chk("cc_p1_act_opp", 32'(bus.p1_action_opponent), 32'(A_CHECK));

    // Bet / raise / call
    new_hand(8'd100, 8'd100);
    start_round(1'b0);
    base_done = done_cnt;
    do_move(1'b0, A_BET, 8'd10, 1'b0);
    do_move(1'b1, A_RAISE, 8'd20, 1'b0);
    chk("brc_no_early_done", done_cnt - base_done, 32'd0);
    chk("brc_p0_bet_opp", 32'(bus.p0_bet_opponent), 32'd30);
    do_move(1'b0, A_CALL, 8'd0, 1'b0);
    wait_done(base_done);
    chk("brc_pot", 32'(pot_size), 32'd60);
    chk("brc_money0", 32'(bus.p0_money_left), 32'd70);
    chk("brc_money1", 32'(bus.p1_money_left), 32'd70);
    chk("brc_p1_bet_opp", 32'(bus.p1_bet_opponent), 32'd20);

    // Repeated illegal checks force a fold
    new_hand(8'd100, 8'd100);
    start_round(1'b0);
    base_done = done_cnt;
    base_deal = deal_cnt;
    base_inv  = inv_cnt;
    do_move(1'b0, A_BET, 8'd10, 1'b0);
    do_move(1'b1, A_CHECK, 8'd0, 1'b1);
    chk("inv_money1_a", 32'(bus.p1_money_left), 32'd100);
    do_move(1'b1, A_CHECK, 8'd0, 1'b1);
    do_move(1'b1, A_CHECK, 8'd0, 1'b1);
    wait_deal(base_deal);
    chk("inv_winner", 32'(winner_seen), 32'd0);
    chk("inv_count", inv_cnt - base_inv, 32'd3);
    chk("inv_no_done", done_cnt - base_done, 32'd0);
    chk("inv_money0", 32'(bus.p0_money_left), 32'd90);
    chk("inv_money1", 32'(bus.p1_money_left), 32'd100);
    chk("inv_pot", 32'(pot_size), 32'd10);

    // Short all-in called
    new_hand(8'd40, 8'd100);
    start_round(1'b0);
    base_done = done_cnt;
    do_move(1'b0, A_ALLIN, 8'd0, 1'b0);
    do_move(1'b1, A_CALL, 8'd0, 1'b0);
    wait_done(base_done);
    chk("ai_pot", 32'(pot_size), 32'd80);
    chk("ai_money0", 32'(bus.p0_money_left), 32'd0);
    chk("ai_money1", 32'(bus.p1_money_left), 32'd60);
    chk("ai_p1_act_opp", 32'(bus.p1_action_opponent), 32'(A_ALLIN));
    chk("ai_p1_bet_opp", 32'(bus.p1_bet_opponent), 32'd40);

    // All-in over a bet, closed by the caller
    new_hand(8'd100, 8'd100);
    start_round(1'b0);
    base_done = done_cnt;
    do_move(1'b0, A_BET, 8'd10, 1'b0);
    do_move(1'b1, A_ALLIN, 8'd0, 1'b0);
    chk("ai2_no_early_done", done_cnt - base_done, 32'd0);
    do_move(1'b0, A_CALL, 8'd0, 1'b0);
    wait_done(base_done);
    chk("ai2_pot", 32'(pot_size), 32'd200);
    chk("ai2_money", 32'({bus.p1_money_left, bus.p0_money_left}), 32'd0);
    chk("ai2_p0_bet_opp", 32'(bus.p0_bet_opponent), 32'd100);

    // Reset in the middle of a handshake
    new_hand(8'd50, 8'd50);
    start_round(1'b0);
    n = 0;
    while (bus.p0_dealer_request_action !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rh_request_up", 32'(n < 20), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rh_req_low", 32'({bus.p1_dealer_request_action, bus.p0_dealer_request_action}), 32'd0);
    chk("rh_money", 32'({bus.p1_money_left, bus.p0_money_left}), 32'd0);
    chk("rh_act_opp", 32'({bus.p1_action_opponent, bus.p0_action_opponent}), 32'd0);
    base_ack = ack_cnt;
    drive(1'b0, 1'b1, A_BET, 8'd10);
    repeat (6) @(negedge clk);
    drive(1'b0, 1'b0, A_NONE, 8'd0);
    chk("rh_no_ack", ack_cnt - base_ack, 32'd0);
    chk("rh_pot", 32'(pot_size), 32'd0);
    chk("rh_req_still_low", 32'(bus.p0_dealer_request_action), 32'd0);
    chk("rh_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/poker_dealer_betting_round.md
Name: poker_dealer_betting_round

Overview:
- Dealer-side betting-round controller sitting directly downstream of the two poker player bots.
- Requests an action from each player in turn and consumes each player's output_valid/action/make_bet handshake.
- Validates each move against stacks and the amount to call, updates the pot and stacks, and returns the per-player feedback the bots consume: dealer_acknowledge, invalid_move, action_opponent, bet_opponent, money_left, pot_size, betting_round_done, next_deal.

Parameters:
MAX_INVALID, 3, consecutive invalid moves by one player before that player is forced to fold (1..7)

Ports:
clk  input  1  system clock
rst  input  1  reset
hand_start  input  1  pulse: load stacks, clear pot, begin new hand
stack0_init  input  8  player0 starting stack (caller guarantees stack0_init+stack1_init <= 255)
stack1_init  input  8  player1 starting stack
round_start  input  1  pulse: begin a betting round (ignored unless IDLE)
first_player  input  1  player to act first this round
p0_output_valid, p1_output_valid  input  1 each  player move valid
p0_action, p1_action  input  3 each  action code
p0_make_bet, p1_make_bet  input  8 each  bet/raise amount
p0_dealer_request_action, p1_dealer_request_action  output  1 each  level, held until move accepted
p0_dealer_acknowledge, p1_dealer_acknowledge  output  1 each  one-cycle pulse per received move
p0_invalid_move, p1_invalid_move  output  1 each  one-cycle pulse, coincident with acknowledge
p0_action_opponent, p1_action_opponent  output  3 each  other player's last legal action
p0_bet_opponent, p1_bet_opponent  output  8 each  chips the other player paid on that action
p0_money_left, p1_money_left  output  8 each  current stacks
pot_size  output  8  pot
betting_round_done  output  1  one-cycle pulse, both players
next_deal  output  1  one-cycle pulse when hand ends by fold
winner  output  1  valid with next_deal

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; action_opponent = NO_ACTION (000); FSM in IDLE.
- hand_start (any state except mid-reset): stacks <= init values; pot, committed counts, invalid counters <= 0; FSM <= IDLE.
- Action codes: NO_ACTION 000, FOLD 001, CHECK 010, ALL_IN 011, CALL 100, BET 110, RAISE 111.
- Definitions: cur = player to act; to_call = committed[other] - committed[cur] (committed cleared at round_start).
- Legality and chips paid:
  - FOLD: always legal; pays 0.
  - CHECK: legal iff to_call == 0; pays 0.
  - CALL: legal iff 0 < to_call <= stack; pays to_call.
  - BET: legal iff to_call == 0 and 1 <= make_bet <= stack; pays make_bet.
  - RAISE: legal iff to_call > 0, make_bet > 0, and to_call + make_bet <= stack (9-bit compare); pays to_call + make_bet.
  - ALL_IN: legal iff stack > 0; pays stack.
  - NO_ACTION: always illegal.
- FSM states: IDLE, REQ, WAIT_VALID, EVAL, ACK, WAIT_DROP, NEXT, DONE.
  - IDLE: on round_start, cur <= first_player, clear acted flags -> REQ.
  - REQ: raise request[cur] -> WAIT_VALID.
  - WAIT_VALID: on output_valid[cur] sampled high at edge k, latch action and bet -> EVAL. The non-current player's valid is ignored.
  - EVAL: at edge k+1, on a legal move, update stack, committed, pot, the opponent-facing action/bet outputs, acted[cur], and clear invalid_cnt[cur]. On an illegal move, increment invalid_cnt[cur]. Drop request[cur]. -> ACK.
  - ACK: the cycle after edge k+1, dealer_acknowledge[cur] = 1, plus invalid_move[cur] if illegal. -> WAIT_DROP.
  - WAIT_DROP: wait for output_valid[cur] low, then:
    - FOLD (real or forced): next_deal pulse, winner = other -> IDLE.
    - Illegal with invalid_cnt < MAX_INVALID: -> REQ, same cur.
    - Illegal with invalid_cnt == MAX_INVALID: treat as FOLD.
    - Legal: -> NEXT.
  - NEXT: the round is complete when acted[0] && acted[1] && (committed equal, or the lower-committed player's stack == 0). Complete -> DONE; else cur <= other -> REQ.
  - DONE: betting_round_done pulse for one cycle -> IDLE. Excess uncalled chips remain in the pot.
- Simultaneous events: hand_start has priority over round_start and over all FSM activity. rst overrides everything, including mid-handshake: request lines drop next cycle.

Test Plan:
- Bet/call: stacks 100/100, round_start first=0, p0 BET 10, p1 CALL -> pot 20, money 90/90, p1_action_opponent=110, p1_bet_opponent=10, one betting_round_done pulse.
- Check/check: p0 CHECK, p1 CHECK -> pot unchanged, betting_round_done after p1 ack, no invalid pulses.
- Bet/raise/call: p0 BET 10, p1 RAISE 20 (pays 30), p0 CALL (pays 20) -> pot 60, money 70/70, done only after p0's call.
- Invalid then forced fold: p0 BET 10, p1 CHECK three times -> three p1_invalid_move pulses coincident with ack, stacks unchanged, p1 re-requested each time; third -> next_deal, winner=0.
- All-in short: stacks 40/100, p0 ALL_IN, p1 CALL -> p1 pays 40, pot 80, money 0/60, round done. Also: p1 ALL_IN 100 after p0 BET 10 -> round done once p0 responds.
- Reset mid-handshake: assert rst while p0_dealer_request_action high in WAIT_VALID -> next cycle all outputs 0, FSM IDLE, a later p0_output_valid is ignored.
